// File: rtl/lifo_stack_reg.sv
// Register-based LIFO holding move/direction history for maze backtracking.
// Supports push, pop, replace-top and synchronous clear, with a sticky misuse flag.
module lifo_stack_reg #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam logic [AW:0] CntOne  = (AW+1)'(1);
   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      count_q, count_d;
   logic             err_q, err_d;
   logic [AW-1:0]    wr_idx, top_idx;
   logic             empty_w, full_w;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CntFull);
   // Both indices are only used when they are in range (not full / not empty).
   assign wr_idx  = AW'(count_q);
   assign top_idx = AW'(count_q - CntOne);

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      err_d   = err_q;
      if (clr) begin
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (full_w) begin
                  err_d = 1'b1;
               end else begin
                  mem_d[wr_idx] = dataIn;
                  count_d       = count_q + CntOne;
               end
            end
            2'b01: begin
               if (empty_w) begin
                  err_d = 1'b1;
               end else begin
                  count_d = count_q - CntOne;
               end
            end
            2'b11: begin
               // Replace top; on an empty stack this degenerates to a plain push.
               if (empty_w) begin
                  mem_d[wr_idx] = dataIn;
                  count_d       = CntOne;
               end else begin
                  mem_d[top_idx] = dataIn;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      dataOut = empty_w ? '0 : mem_q[top_idx];
      count   = count_q;
      empty   = empty_w;
      full    = full_w;
      err     = err_q;
   end

endmodule

// File: tb/tb_lifo_stack_reg.sv
// Scoreboard bench for lifo_stack_reg (WIDTH=4, DEPTH=4); each output vector is
// {count, empty, full, err, dataOut}.
module tb_lifo_stack_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [3:0] dataIn = 4'h0;
   logic [3:0] dataOut;
   logic [2:0] count;
   logic       empty, full, err;

   int n_vec = 0;
   int n_err = 0;

   logic [9:0] sb [$];
   logic [9:0] exp_v;

   logic [3:0] m_mem [4];
   int         m_cnt;
   logic       m_err;

   lifo_stack_reg #(.WIDTH(4), .DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .push    (push),
      .pop     (pop),
      .dataIn  (dataIn),
      .dataOut (dataOut),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] model_vec();
      logic [3:0] d;
      d = (m_cnt == 0) ? 4'h0 : m_mem[m_cnt-1];
      return {3'(m_cnt), m_cnt == 0, m_cnt == 4, m_err, d};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
   endtask

   // Drive one cycle, advance the model and queue the expected outputs.
   task automatic drive(input logic c, input logic p, input logic o, input logic [3:0] d);
      @(negedge clk);
      clr = c; push = p; pop = o; dataIn = d;
      if (c) begin
         m_cnt = 0;
         m_err = 1'b0;
      end else if (p && o) begin
         if (m_cnt == 0) begin
            m_mem[0] = d;
            m_cnt = 1;
         end else begin
            m_mem[m_cnt-1] = d;
         end
      end else if (p) begin
         if (m_cnt == 4) m_err = 1'b1;
         else begin
            m_mem[m_cnt] = d;
            m_cnt++;
         end
      end else if (o) begin
         if (m_cnt == 0) m_err = 1'b1;
         else m_cnt--;
      end
      @(posedge clk);
      #1;
      clr = 1'b0; push = 1'b0; pop = 1'b0;
      sb.push_back(model_vec());
   endtask

   task automatic test_reset();
      #2;
      model_reset();
      sb.push_back(model_vec());
      exp_v = sb.pop_front();
      n_vec++;
      if ({count, empty, full, err, dataOut} !== exp_v) begin
         n_err++;
         $display("FAIL reset: observed %h expected %h", {count, empty, full, err, dataOut}, exp_v);
      end
      #1 rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [3:0] vals [5] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h7};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b0, vals[i]);
         exp_v = sb.pop_front();
         n_vec++;
         if ({count, empty, full, err, dataOut} !== exp_v) begin
            n_err++;
            $display("FAIL fill[%0d]: observed %h expected %h", i,
                     {count, empty, full, err, dataOut}, exp_v);
         end
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 4'h0);
         exp_v = sb.pop_front();
         n_vec++;
         if ({count, empty, full, err, dataOut} !== exp_v) begin
            n_err++;
            $display("FAIL drain[%0d]: observed %h expected %h", i,
                     {count, empty, full, err, dataOut}, exp_v);
         end
      end
   endtask

   task automatic test_replace();
      // clr, push 2, replace 9, pop, replace-on-empty 4
      logic [3:0] ops [5] = '{4'b1000, 4'b0100, 4'b0110, 4'b0010, 4'b0110};
      logic [3:0] dat [5] = '{4'h0, 4'h2, 4'h9, 4'h0, 4'h4};
      for (int i = 0; i < 5; i++) begin
         drive(ops[i][3], ops[i][2], ops[i][1], dat[i]);
         exp_v = sb.pop_front();
         n_vec++;
         if ({count, empty, full, err, dataOut} !== exp_v) begin
            n_err++;
            $display("FAIL replace[%0d]: observed %h expected %h", i,
                     {count, empty, full, err, dataOut}, exp_v);
         end
      end
   endtask

   task automatic test_clear();
      // Reach count=3 with err=1, then clr together with push.
      logic [3:0] ops [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b1100};
      logic [3:0] dat [6] = '{4'h6, 4'h8, 4'hB, 4'hF, 4'h0, 4'h5};
      for (int i = 0; i < 6; i++) begin
         drive(ops[i][3], ops[i][2], ops[i][1], dat[i]);
         exp_v = sb.pop_front();
         n_vec++;
         if ({count, empty, full, err, dataOut} !== exp_v) begin
            n_err++;
            $display("FAIL clear[%0d]: observed %h expected %h", i,
                     {count, empty, full, err, dataOut}, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 1'b0, 4'hE);
      void'(sb.pop_front());
      drive(1'b0, 1'b1, 1'b0, 4'hD);
      exp_v = sb.pop_front();
      n_vec++;
      if ({count, empty, full, err, dataOut} !== exp_v) begin
         n_err++;
         $display("FAIL async_pre: observed %h expected %h", {count, empty, full, err, dataOut},
                  exp_v);
      end
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      model_reset();
      sb.push_back(model_vec());
      exp_v = sb.pop_front();
      n_vec++;
      if ({count, empty, full, err, dataOut} !== exp_v) begin
         n_err++;
         $display("FAIL async_rst: observed %h expected %h", {count, empty, full, err, dataOut},
                  exp_v);
      end
      #1 rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 4'h1);
      exp_v = sb.pop_front();
      n_vec++;
      if ({count, empty, full, err, dataOut} !== exp_v) begin
         n_err++;
         $display("FAIL async_post: observed %h expected %h", {count, empty, full, err, dataOut},
                  exp_v);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_drain();
      test_replace();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
